qam_burst_ctrl: RTL and testbench
=================================

QAM_BURST_CTRL -- requirements
Module: qam_burst_ctrl

Interface
- REQ-001: The block SHALL have parameter OSR_LOG2, default 4, meaning log2 of samples per symbol (16 samples per symbol).
- REQ-002: The block SHALL have parameter PRE_LEN, default 8, meaning the number of preamble symbols.
- REQ-003: The block SHALL have parameter FLUSH_LEN, default 4, meaning the number of zero symbols appended to drain the filter tail.
- REQ-004: Port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
- REQ-005: Port rst_n, input, 1 bit: asynchronous, active-low reset.
- REQ-006: Port start, input, 1 bit: burst request, sampled in IDLE only.
- REQ-007: Port abort, input, 1 bit: synchronous burst cancel.
- REQ-008: Port payload_len, input, 8 bits: payload symbol count, sampled when start is accepted.
- REQ-009: Port sym_valid, input, 1 bit: upstream payload symbol available.
- REQ-010: Port sym_ready, output, 1 bit: payload symbol is consumed when sym_valid && sym_ready.
- REQ-011: Port ready_mapper, output, 1 bit: symbol strobe to the mapper.
- REQ-012: Port sel_zero_pad, output, 1 bit: 0 passes the symbol, 1 inserts a zero sample.
- REQ-013: Port sel_src, output, 2 bits: 00 = zero, 01 = preamble, 10 = payload.
- REQ-014: Port pre_idx, output, 3 bits: preamble ROM index.
- REQ-015: Port sel_carrier, output, OSR_LOG2 bits: carrier phase index.
- REQ-016: Port busy, output, 1 bit: high during a burst.
- REQ-017: Port done, output, 1 bit: one-cycle pulse at burst completion.
- REQ-018: Port underrun, output, 1 bit: sticky underrun flag.

Function
- REQ-019: The FSM SHALL have states IDLE, PREAMBLE, PAYLOAD, FLUSH and DONE.
- REQ-020: IDLE SHALL go to PREAMBLE on start && payload_len != 0. A start with payload_len == 0 SHALL be ignored.
- REQ-021: A phase counter SHALL run 0 to 2^OSR_LOG2-1 and wrap while busy. It SHALL be held at 0 in IDLE and DONE.
- REQ-022: Each state SHALL last a whole number of symbol periods; state changes occur only on phase wrap.
- REQ-023: PREAMBLE SHALL last PRE_LEN symbols, PAYLOAD payload_len symbols, and FLUSH FLUSH_LEN symbols.
- REQ-024: DONE SHALL last one cycle, during which done=1, then the FSM SHALL return to IDLE.
- REQ-025: All outputs SHALL be registered.
- REQ-026: ready_mapper=1 and sel_zero_pad=0 SHALL occur exactly in cycles with phase==0 in PREAMBLE, PAYLOAD or FLUSH; otherwise ready_mapper=0 and sel_zero_pad=1.
- REQ-027: The first ready_mapper SHALL occur 1 cycle after start is sampled.
- REQ-028: sym_ready SHALL be 1 only at phase==0 in PAYLOAD.
- REQ-029: If sym_valid=0 at a payload slot, the symbol SHALL still count, sel_src SHALL be 00 for that symbol, and underrun SHALL be set.
- REQ-030: underrun SHALL be cleared only by an accepted start or by reset.
- REQ-031: pre_idx SHALL increment per preamble symbol, start at 0, and wrap modulo 8.
- REQ-032: sel_carrier SHALL equal the phase counter.
- REQ-033: busy SHALL be 1 in PREAMBLE, PAYLOAD and FLUSH.
- REQ-034: start while busy SHALL be ignored.
- REQ-035: abort in any busy state SHALL force IDLE next cycle: no done, phase=0, underrun held.
- REQ-036: If abort and start arrive together in IDLE, abort wins and the start is dropped.
- REQ-037: payload_len SHALL be latched at start acceptance; changes during the burst SHALL have no effect.

Reset
- REQ-038: While rst_n=0, the block SHALL be in state IDLE with phase=0, ready_mapper=0, sel_zero_pad=1, sel_src=00, pre_idx=0, sel_carrier=0, sym_ready=0, busy=0, done=0 and underrun=0.
- REQ-039: Reset mid-burst SHALL abandon the burst with no done pulse.

Configuration
- REQ-040: Macro QAM_PREAMBLE_EN SHALL select preamble support.
- REQ-041: With QAM_PREAMBLE_EN defined, the block SHALL behave as specified above.
- REQ-042: Without QAM_PREAMBLE_EN, the PREAMBLE state SHALL be absent, IDLE SHALL go directly to PAYLOAD, pre_idx SHALL be constant 0, and sel_src SHALL never be 01.

Structure
- REQ-043: The shared package qam_pkg SHALL hold the state encoding, the sel_src codes (SRC_ZERO, SRC_PRE, SRC_PAY) and the default OSR_LOG2.
- REQ-044: One sub-module, qam_phase_cnt, SHALL provide the phase counter with clear, enable and a wrap strobe. All other logic SHALL stay in qam_burst_ctrl.

Verification
- REQ-045: With macro on, defaults, payload_len=3, sym_valid=1: busy high for 240 cycles (15 symbols), 15 ready_mapper pulses spaced 16 cycles, sel_src sequence 01×8, 10×3, 00×4, done pulsed once, underrun=0.
- REQ-046: With macro off, payload_len=3: busy for 112 cycles, no sel_src=01, pre_idx always 0.
- REQ-047: sym_valid dropped at the 2nd payload slot: that symbol has sel_src=00, underrun=1 after it; the next start clears underrun.
- REQ-048: abort asserted at phase 7 of payload symbol 1: IDLE next cycle, busy=0, sel_carrier=0, no done; a start afterwards runs a full burst.
- REQ-049: start with payload_len=0, and start pulsed mid-burst: both ignored, with burst length unchanged.
- REQ-050: rst_n asserted mid-FLUSH: all outputs at reset values immediately, no done; after release, a new start gives normal 240-cycle timing.

Source files
------------

// File: rtl/qam_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : qam_pkg
//  Description : Shared definitions for the QAM burst controller: FSM state
//                encoding, sample-source select codes, default oversampling.
//                Macro QAM_PREAMBLE_EN adds the PREAMBLE state.
//  Revision    : 1.0 - initial release
// ============================================================================
package qam_pkg;

    // log2 of samples per symbol used when the instantiation does not override it
    localparam int OSR_LOG2_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
`ifdef QAM_PREAMBLE_EN
        ST_PRE   = 3'd1,
`endif
        ST_PAY   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Sample-source select codes driven on sel_src
    localparam logic [1:0] SRC_ZERO = 2'b00;
    localparam logic [1:0] SRC_PRE  = 2'b01;
    localparam logic [1:0] SRC_PAY  = 2'b10;

    // A burst is in progress in every state except IDLE and DONE
    function automatic logic is_busy(input state_t s);
        return (s != ST_IDLE) && (s != ST_DONE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/qam_phase_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : qam_phase_cnt
//  Description : Free-running sample-phase counter within a symbol period,
//                with synchronous clear, count enable and a wrap strobe that
//                flags the last sample of the symbol.
//  Revision    : 1.0 - initial release
// ============================================================================
module qam_phase_cnt #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] phase_o,
    output logic             wrap_o
);

    logic [WIDTH-1:0] phase_q;

    // Clear has priority over counting; the counter wraps naturally at 2^WIDTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
        end else if (clr_i) begin
            phase_q <= '0;
        end else if (en_i) begin
            phase_q <= phase_q + WIDTH'(1);
        end
    end

    assign phase_o = phase_q;
    assign wrap_o  = en_i && (phase_q == {WIDTH{1'b1}});

endmodule
`default_nettype wire

// File: rtl/qam_burst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : qam_burst_ctrl
//  Description : Burst sequencer for a QAM transmitter: preamble, payload and
//                flush symbols, one mapper strobe per symbol period, zero
//                stuffing between strobes, payload handshake and underrun flag.
//                Macro QAM_PREAMBLE_EN enables the preamble phase; without it
//                bursts start directly with payload.
//  Revision    : 1.0 - initial release
// ============================================================================
module qam_burst_ctrl
    import qam_pkg::*;
#(
    parameter int OSR_LOG2  = OSR_LOG2_DEF,
    parameter int PRE_LEN   = 8,
    parameter int FLUSH_LEN = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [7:0]          payload_len,
    input  logic                sym_valid,
    output logic                sym_ready,
    output logic                ready_mapper,
    output logic                sel_zero_pad,
    output logic [1:0]          sel_src,
    output logic [2:0]          pre_idx,
    output logic [OSR_LOG2-1:0] sel_carrier,
    output logic                busy,
    output logic                done,
    output logic                underrun
);

    // Symbol counter must cover the longest configured phase
    localparam int c_len_a   = (PRE_LEN > FLUSH_LEN) ? PRE_LEN : FLUSH_LEN;
    localparam int c_max_len = (c_len_a > 255) ? c_len_a : 255;
    localparam int c_cnt_w   = $clog2(c_max_len + 1);

    state_t               state_q, state_d, w_after;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d, w_last;
    logic [7:0]           len_q, len_d;
    logic                 ready_mapper_q, sel_zero_pad_q, sym_ready_q;
    logic                 busy_q, done_q, underrun_q;
    logic [1:0]           sel_src_q, sel_src_d;
    logic                 w_accept, w_wrap, w_phase_clr, w_phase_en;
    logic                 w_zero_next, w_slot_miss;
    logic [OSR_LOG2-1:0]  w_phase;

    qam_phase_cnt #(
        .WIDTH (OSR_LOG2)
    ) u_phase (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (w_phase_clr),
        .en_i    (w_phase_en),
        .phase_o (w_phase),
        .wrap_o  (w_wrap)
    );

    // Next-state, symbol counting and burst-length latch; abort overrides all
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        w_accept = 1'b0;
        w_last   = '0;
        w_after  = ST_IDLE;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort && (payload_len != 8'd0)) begin
                    w_accept = 1'b1;
                    len_d    = payload_len;
                    cnt_d    = '0;
`ifdef QAM_PREAMBLE_EN
                    state_d  = ST_PRE;
`else
                    state_d  = ST_PAY;
`endif
                end
            end
`ifdef QAM_PREAMBLE_EN
            ST_PRE: begin
                w_last  = c_cnt_w'(PRE_LEN - 1);
                w_after = ST_PAY;
            end
`endif
            ST_PAY: begin
                w_last  = c_cnt_w'(len_q) - c_cnt_w'(1);
                w_after = ST_FLUSH;
            end
            ST_FLUSH: begin
                w_last  = c_cnt_w'(FLUSH_LEN - 1);
                w_after = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (is_busy(state_q)) begin
            if (abort) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else if (w_wrap) begin
                if (cnt_q == w_last) begin
                    state_d = w_after;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_cnt_w'(1);
                end
            end
        end
    end

    // Phase runs only while a burst continues; any entry/exit forces it to 0
    assign w_phase_en  = is_busy(state_q);
    assign w_phase_clr = !is_busy(state_q) || !is_busy(state_d);
    assign w_zero_next = w_phase_clr || w_wrap;
    // A payload slot was offered but nothing was there to take
    assign w_slot_miss = sym_ready_q && !sym_valid;

    // Source select for the next cycle; a missed payload slot demotes the
    // current symbol to zero for the remainder of its period
    always_comb begin
        sel_src_d = SRC_ZERO;
        case (state_d)
`ifdef QAM_PREAMBLE_EN
            ST_PRE: sel_src_d = SRC_PRE;
`endif
            ST_PAY: begin
                if (w_zero_next)      sel_src_d = SRC_PAY;
                else if (w_slot_miss) sel_src_d = SRC_ZERO;
                else                  sel_src_d = sel_src_q;
            end
            default: sel_src_d = SRC_ZERO;
        endcase
    end

    // FSM state and all registered outputs, derived from the next state/phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            len_q          <= '0;
            busy_q         <= 1'b0;
            ready_mapper_q <= 1'b0;
            sel_zero_pad_q <= 1'b1;
            sym_ready_q    <= 1'b0;
            done_q         <= 1'b0;
            underrun_q     <= 1'b0;
            sel_src_q      <= SRC_ZERO;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            len_q          <= len_d;
            busy_q         <= is_busy(state_d);
            ready_mapper_q <= is_busy(state_d) && w_zero_next;
            sel_zero_pad_q <= !(is_busy(state_d) && w_zero_next);
            sym_ready_q    <= (state_d == ST_PAY) && w_zero_next;
            done_q         <= (state_d == ST_DONE);
            underrun_q     <= w_accept ? 1'b0 : (underrun_q | w_slot_miss);
            sel_src_q      <= sel_src_d;
        end
    end

`ifdef QAM_PREAMBLE_EN
    logic [2:0] pre_idx_q;

    // Preamble ROM index follows the preamble symbol count modulo 8
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_idx_q <= 3'd0;
        end else begin
            pre_idx_q <= (state_d == ST_PRE) ? cnt_d[2:0] : 3'd0;
        end
    end

    assign pre_idx = pre_idx_q;
`else
    assign pre_idx = 3'd0;
`endif

    assign sym_ready    = sym_ready_q;
    assign ready_mapper = ready_mapper_q;
    assign sel_zero_pad = sel_zero_pad_q;
    assign sel_src      = sel_src_q;
    assign sel_carrier  = w_phase;
    assign busy         = busy_q;
    assign done         = done_q;
    assign underrun     = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_qam_burst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qam_burst_ctrl
//  Description : Directed self-checking bench for qam_burst_ctrl: burst
//                timing, source sequence, underrun, abort, ignored starts and
//                asynchronous reset. Works with or without QAM_PREAMBLE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_qam_burst_ctrl;

`ifdef QAM_PREAMBLE_EN
    localparam int NPRE = 8;
`else
    localparam int NPRE = 0;
`endif
    localparam int NFLUSH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] payload_len = 8'd0;
    logic       sym_valid = 1'b1;
    logic       sym_ready, ready_mapper, sel_zero_pad, busy, done, underrun;
    logic [1:0] sel_src;
    logic [2:0] pre_idx;
    logic [3:0] sel_carrier;

    always #5 clk = ~clk;

    qam_burst_ctrl #(
        .OSR_LOG2  (4),
        .PRE_LEN   (8),
        .FLUSH_LEN (NFLUSH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .payload_len  (payload_len),
        .sym_valid    (sym_valid),
        .sym_ready    (sym_ready),
        .ready_mapper (ready_mapper),
        .sel_zero_pad (sel_zero_pad),
        .sel_src      (sel_src),
        .pre_idx      (pre_idx),
        .sel_carrier  (sel_carrier),
        .busy         (busy),
        .done         (done),
        .underrun     (underrun)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Per-burst observations
    int         cyc, busy_cnt, rm_cnt, sr_cnt, done_cnt, space_bad, pad_bad, last_rm;
    logic [1:0] seq  [0:31];
    logic [2:0] pidx [0:31];
    bit         rst_hit;

    // Scenario knobs (-1 = off)
    int miss_slot = -1;
    int pulse_at  = -1;
    int abort_sym = -1;
    int rst_rm    = -1;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready_mapper"}, ready_mapper, 0);
        chk({tag, "_sel_zero_pad"}, sel_zero_pad, 1);
        chk({tag, "_sel_src"},      sel_src, 0);
        chk({tag, "_pre_idx"},      pre_idx, 0);
        chk({tag, "_sel_carrier"},  sel_carrier, 0);
        chk({tag, "_sym_ready"},    sym_ready, 0);
        chk({tag, "_busy"},         busy, 0);
        chk({tag, "_done"},         done, 0);
        chk({tag, "_underrun"},     underrun, 0);
    endtask

    task automatic clr_stats();
        cyc = 0; busy_cnt = 0; rm_cnt = 0; sr_cnt = 0; done_cnt = 0;
        space_bad = 0; pad_bad = 0; last_rm = 0; rst_hit = 1'b0;
        for (int i = 0; i < 32; i++) begin
            seq[i]  = 2'b11;
            pidx[i] = 3'b111;
        end
    endtask

    // One clock: sample at the falling edge, then drive reactive stimulus
    task automatic step();
        @(negedge clk);
        cyc++;
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        if (ready_mapper) begin
            if (rm_cnt > 0 && (cyc - last_rm) != 16) space_bad++;
            last_rm = cyc;
            rm_cnt++;
        end
        if (ready_mapper == sel_zero_pad) pad_bad++;
        if (sym_ready) begin
            sr_cnt++;
            if (!ready_mapper) pad_bad++;
        end
        if (busy && sel_carrier == 4'd8 && rm_cnt > 0 && rm_cnt <= 32) begin
            seq[rm_cnt-1]  = sel_src;
            pidx[rm_cnt-1] = pre_idx;
        end
        sym_valid = !(sym_ready && (sr_cnt - 1) == miss_slot);
        start     = (cyc == pulse_at);
        abort     = (abort_sym >= 0) && busy && (sr_cnt == abort_sym + 1) &&
                    (rm_cnt == NPRE + abort_sym + 1) && (sel_carrier == 4'd7);
        if (rst_rm >= 0 && busy && rm_cnt == rst_rm && sel_carrier == 4'd5) begin
            rst_n = 1'b0;
            #1;
            rst_hit = 1'b1;
            chk_idle("rst_async");
        end
    endtask

    task automatic run_burst(input int len);
        int guard;
        clr_stats();
        payload_len = 8'(len);
        start = 1'b1;
        step();
        chk("first_strobe", ready_mapper, 1);
        chk("underrun_clr", underrun, 0);
        payload_len = 8'd1;
        guard = 0;
        while (busy && guard < 2000) begin
            step();
            guard++;
        end
        chk("burst_end", busy, 0);
        step();
    endtask

    task automatic check_seq(input int len, input int miss);
        int sbad, pbad;
        logic [1:0] es;
        logic [2:0] ep;
        sbad = 0; pbad = 0;
        for (int i = 0; i < NPRE + len + NFLUSH; i++) begin
            if (i < NPRE) begin
                es = 2'b01; ep = 3'(i % 8);
            end else if (i < NPRE + len) begin
                es = ((i - NPRE) == miss) ? 2'b00 : 2'b10; ep = 3'd0;
            end else begin
                es = 2'b00; ep = 3'd0;
            end
            if (seq[i] !== es)  sbad++;
            if (pidx[i] !== ep) pbad++;
        end
        chk("sel_src_seq", sbad, 0);
        chk("pre_idx_seq", pbad, 0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog expired CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $fatal(1);
    end

    initial begin
        clr_stats();
        repeat (3) @(negedge clk);
        chk_idle("reset");
        rst_n = 1'b1;
        step();

        // Nominal burst, payload 3
        run_burst(3);
        chk("nom_busy_cycles", busy_cnt, (NPRE + 3 + NFLUSH) * 16);
        chk("nom_strobes",     rm_cnt, NPRE + 3 + NFLUSH);
        chk("nom_sym_ready",   sr_cnt, 3);
        chk("nom_done",        done_cnt, 1);
        chk("nom_spacing",     space_bad, 0);
        chk("nom_pad",         pad_bad, 0);
        chk("nom_underrun",    underrun, 0);
        check_seq(3, -1);

        // Zero-length start is ignored
        clr_stats();
        payload_len = 8'd0;
        start = 1'b1;
        repeat (20) step();
        chk("len0_busy", busy_cnt, 0);
        chk("len0_strobes", rm_cnt, 0);

        // Missing symbol at the second payload slot
        miss_slot = 1;
        run_burst(3);
        miss_slot = -1;
        chk("miss_busy_cycles", busy_cnt, (NPRE + 3 + NFLUSH) * 16);
        chk("miss_underrun", underrun, 1);
        chk("miss_done", done_cnt, 1);
        check_seq(3, 1);
        run_burst(3);
        chk("after_miss_underrun", underrun, 0);

        // Start pulse mid-burst, with payload_len changed after acceptance
        pulse_at = 50;
        run_burst(2);
        pulse_at = -1;
        chk("midstart_busy_cycles", busy_cnt, (NPRE + 2 + NFLUSH) * 16);
        chk("midstart_done", done_cnt, 1);
        check_seq(2, -1);

        // Abort at phase 7 of payload symbol 1
        abort_sym = 1;
        run_burst(3);
        abort_sym = -1;
        chk("abort_busy_cycles", busy_cnt, (NPRE + 1) * 16 + 8);
        chk("abort_no_done", done_cnt, 0);
        chk("abort_carrier", sel_carrier, 0);
        chk("abort_strobe", ready_mapper, 0);

        // Abort and start together in IDLE: start dropped
        clr_stats();
        payload_len = 8'd3;
        abort = 1'b1;
        start = 1'b1;
        repeat (4) step();
        chk("abort_start_drop", busy_cnt, 0);

        run_burst(3);
        chk("post_abort_busy_cycles", busy_cnt, (NPRE + 3 + NFLUSH) * 16);
        chk("post_abort_done", done_cnt, 1);

        // Asynchronous reset during FLUSH
        rst_rm = NPRE + 3 + 2;
        run_burst(3);
        rst_rm = -1;
        chk("rst_hit", rst_hit, 1);
        chk("rst_no_done", done_cnt, 0);
        rst_n = 1'b1;
        step();
        run_burst(3);
        chk("post_rst_busy_cycles", busy_cnt, (NPRE + 3 + NFLUSH) * 16);
        chk("post_rst_done", done_cnt, 1);
        check_seq(3, -1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
